// File: rtl/module_seq_spi_pkg.sv
// Shared types for the SPI sequencer: control codes seen by the control block,
// internal sequencer states, and the state-to-code mapping.
package module_seq_spi_pkg;

    typedef logic [2:0] ctrl_code_t;

    localparam ctrl_code_t CTR_SEND     = 3'd0;
    localparam ctrl_code_t CTR_PRELOAD1 = 3'd1;
    localparam ctrl_code_t CTR_LOAD     = 3'd2;
    localparam ctrl_code_t CTR_TRANSFER = 3'd3;
    localparam ctrl_code_t CTR_CHECK    = 3'd4;
    localparam ctrl_code_t CTR_PRELOAD2 = 3'd5;
    localparam ctrl_code_t CTR_DOWN     = 3'd6;

    typedef enum logic [3:0] {
        IDLE,
        PRELOAD1,
        LOAD,
        TRANSFER,
        CHECK_A,
        CHECK_B,
        PRELOAD2,
        DOWN
    } seq_state_t;

    // CHECK_A and CHECK_B share one code so the control block sees CHECK for two cycles
    function automatic ctrl_code_t state_code(input seq_state_t s);
        case (s)
            PRELOAD1: return CTR_PRELOAD1;
            LOAD:     return CTR_LOAD;
            TRANSFER: return CTR_TRANSFER;
            CHECK_A:  return CTR_CHECK;
            CHECK_B:  return CTR_CHECK;
            PRELOAD2: return CTR_PRELOAD2;
            DOWN:     return CTR_DOWN;
            default:  return CTR_SEND;
        endcase
    endfunction

endpackage

// File: rtl/module_seq_spi_if.sv
// Sequencer bus: register-bank/control-block inputs and sequencer outputs.
// master = register bank + control block side, slave = sequencer.
interface module_seq_spi_if
    import module_seq_spi_pkg::*;
#(
    parameter int DIV_W = 8
);
    logic             send_i;
    logic             contador_i;
    logic             progress_i;
    logic [DIV_W-1:0] div_i;
    ctrl_code_t       control_o;
    logic             clk_fn_o;
    logic             sclk_o;
    logic             busy_o;
    logic             done_o;
    logic             clr_send_o;
    logic             err_o;

    modport master (
        output send_i, contador_i, progress_i, div_i,
        input  control_o, clk_fn_o, sclk_o, busy_o, done_o, clr_send_o, err_o
    );

    modport slave (
        input  send_i, contador_i, progress_i, div_i,
        output control_o, clk_fn_o, sclk_o, busy_o, done_o, clr_send_o, err_o
    );
endinterface

// File: rtl/module_seq_spi_div.sv
// SCLK divider: half-period of max(div_i,1) clk_i cycles while enabled,
// one-cycle clk_fn tick on each SCLK rising edge. Cleared whenever disabled.
module module_div_spi #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             sclk_o,
    output logic             clk_fn_o
);
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] term;
    logic             last;
    logic             sclk_q;
    logic             fn_q;

    assign term = (div_i == '0) ? DIV_W'(1) : div_i;
    // >= so a divisor shrunk below the current count wraps on the next cycle
    assign last = (cnt_q >= term - DIV_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            fn_q   <= 1'b0;
        end else if (last) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
            fn_q   <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + DIV_W'(1);
            fn_q   <= 1'b0;
        end
    end

    // Gate with enable so outputs drop in the first cycle after TRANSFER exits
    assign sclk_o   = sclk_q & en_i;
    assign clk_fn_o = fn_q & en_i;

endmodule

// File: rtl/module_seq_spi.sv
// SPI sequencer: send-edge start, PRELOAD/LOAD/TRANSFER/CHECK per word, DOWN on completion.
// Optional transfer watchdog enabled by defining SPI_TIMEOUT_EN.
module module_seq_spi
    import module_seq_spi_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int TO_W  = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    module_seq_spi_if.slave  bus
);
    seq_state_t state;
    seq_state_t nxt;
    logic       send_q;
    logic       rst_q;
    logic       wd_fire;
    logic       to_err;

`ifdef SPI_TIMEOUT_EN
    logic [TO_W-1:0] wd_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || state != TRANSFER) wd_q <= '0;
        else                            wd_q <= wd_q + TO_W'(1);
    end

    // Fires on the cycle whose increment would reach all-ones
    assign wd_fire = (state == TRANSFER) && (wd_q == {{(TO_W-1){1'b1}}, 1'b0});
`else
    assign wd_fire = 1'b0 & (TO_W > 0);
`endif

    always_comb begin
        nxt    = state;
        to_err = 1'b0;
        case (state)
            // rst_q masks a send level held high across reset release
            IDLE:     if (bus.send_i && !send_q && !rst_q) nxt = PRELOAD1;
            PRELOAD1: nxt = LOAD;
            LOAD:     nxt = TRANSFER;
            TRANSFER: begin
                if (bus.contador_i) nxt = CHECK_A;
                else if (wd_fire) begin
                    nxt    = DOWN;
                    to_err = 1'b1;
                end
            end
            CHECK_A:  nxt = CHECK_B;
            CHECK_B:  nxt = bus.progress_i ? DOWN : PRELOAD2;
            PRELOAD2: nxt = LOAD;
            DOWN:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            send_q         <= 1'b0;
            rst_q          <= 1'b1;
            bus.control_o  <= CTR_SEND;
            bus.busy_o     <= 1'b0;
            bus.done_o     <= 1'b0;
            bus.clr_send_o <= 1'b0;
            bus.err_o      <= 1'b0;
        end else begin
            state          <= nxt;
            send_q         <= bus.send_i;
            rst_q          <= 1'b0;
            bus.control_o  <= state_code(nxt);
            bus.busy_o     <= (nxt != IDLE);
            bus.done_o     <= (nxt == DOWN);
            bus.clr_send_o <= (nxt == DOWN);
            bus.err_o      <= to_err;
        end
    end

    module_div_spi #(.DIV_W(DIV_W)) u_div (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (state == TRANSFER),
        .div_i    (bus.div_i),
        .sclk_o   (bus.sclk_o),
        .clk_fn_o (bus.clk_fn_o)
    );

endmodule

// File: tb/tb_module_seq_spi.sv
// Scoreboard bench for module_seq_spi: stimulus queues expected control codes and
// done pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_module_seq_spi;
    import module_seq_spi_pkg::*;

    localparam int DIV_W = 8;
    localparam int TO_W  = 4;

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } ctrl_ev_t;

    typedef struct {
        logic err;
        int   cyc;
    } done_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   exp_half = 1;

    ctrl_ev_t ctrl_q[$];
    done_ev_t done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    module_seq_spi_if #(.DIV_W(DIV_W)) bus ();

    module_seq_spi #(.DIV_W(DIV_W), .TO_W(TO_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_xfer();
        int t;
        t = cyc;
        bus.send_i = 1'b1;
        ctrl_q.push_back('{3'd1, t + 1});
        ctrl_q.push_back('{3'd2, t + 2});
        ctrl_q.push_back('{3'd3, t + 3});
        tick(1);
        bus.send_i = 1'b0;
        tick(2);
    endtask

    // Waits w cycles in TRANSFER, then completes one word.
    task automatic run_word(input bit last, input int w);
        int t;
        tick(w);
        t = cyc;
        bus.contador_i = 1'b1;
        bus.progress_i = last;
        ctrl_q.push_back('{3'd4, t + 1});
        if (last) begin
            ctrl_q.push_back('{3'd6, t + 3});
            ctrl_q.push_back('{3'd0, t + 4});
            done_q.push_back('{1'b0, t + 3});
        end else begin
            ctrl_q.push_back('{3'd5, t + 3});
            ctrl_q.push_back('{3'd2, t + 4});
            ctrl_q.push_back('{3'd3, t + 5});
        end
        tick(1);
        bus.contador_i = 1'b0;
        tick(last ? 3 : 4);
        bus.progress_i = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        n_run++;
        if ({bus.control_o, bus.clk_fn_o, bus.sclk_o, bus.busy_o, bus.done_o,
             bus.clr_send_o, bus.err_o} !== 9'd0) begin
            n_fail++;
            $display("FAIL %s: got ctrl=%0d fn=%b sclk=%b busy=%b done=%b clr=%b err=%b, expected all 0",
                     name, bus.control_o, bus.clk_fn_o, bus.sclk_o, bus.busy_o,
                     bus.done_o, bus.clr_send_o, bus.err_o);
        end
    endtask

    // Monitor
    initial begin
        logic [2:0] ctrl_prev;
        logic       sclk_prev;
        int         xfer_t;
        int         last_tick;
        ctrl_ev_t   ce;
        done_ev_t   de;
        ctrl_prev = 3'd0;
        sclk_prev = 1'b0;
        xfer_t    = 0;
        last_tick = -1;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.control_o !== ctrl_prev) begin
                    n_run++;
                    if (ctrl_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL ctrl_seq: got code %0d at cycle %0d, expected no change",
                                 bus.control_o, cyc);
                    end else begin
                        ce = ctrl_q.pop_front();
                        if (bus.control_o !== ce.code || cyc != ce.cyc) begin
                            n_fail++;
                            $display("FAIL ctrl_seq: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                                     bus.control_o, cyc, ce.code, ce.cyc);
                        end
                    end
                    n_run++;
                    if (bus.busy_o !== (bus.control_o != 3'd0)) begin
                        n_fail++;
                        $display("FAIL busy: got %b with code %0d, expected %b",
                                 bus.busy_o, bus.control_o, bus.control_o != 3'd0);
                    end
                    if (bus.control_o == 3'd3) begin
                        xfer_t    = cyc;
                        last_tick = -1;
                    end
                    ctrl_prev = bus.control_o;
                end
                if (bus.control_o !== 3'd3) begin
                    n_run++;
                    if ({bus.sclk_o, bus.clk_fn_o} !== 2'b00) begin
                        n_fail++;
                        $display("FAIL div_idle: got sclk=%b fn=%b at cycle %0d, expected 0 0",
                                 bus.sclk_o, bus.clk_fn_o, cyc);
                    end
                end
                if (bus.clk_fn_o === 1'b1) begin
                    n_run++;
                    if (last_tick < 0) begin
                        if (cyc - xfer_t != exp_half) begin
                            n_fail++;
                            $display("FAIL first_tick: got %0d cycles after TRANSFER entry, expected %0d",
                                     cyc - xfer_t, exp_half);
                        end
                    end else if (cyc - last_tick != 2 * exp_half) begin
                        n_fail++;
                        $display("FAIL tick_period: got %0d, expected %0d", cyc - last_tick, 2 * exp_half);
                    end
                    n_run++;
                    if ({sclk_prev, bus.sclk_o} !== 2'b01) begin
                        n_fail++;
                        $display("FAIL sclk_rise: got prev=%b now=%b at tick, expected 0 1",
                                 sclk_prev, bus.sclk_o);
                    end
                    last_tick = cyc;
                end
                n_run++;
                if (bus.clr_send_o !== bus.done_o || (bus.err_o === 1'b1 && bus.done_o !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL pulse_align: got done=%b clr=%b err=%b at cycle %0d, expected clr==done and err only with done",
                             bus.done_o, bus.clr_send_o, bus.err_o, cyc);
                end
                if (bus.done_o === 1'b1) begin
                    n_run++;
                    if (done_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL done: got done pulse at cycle %0d, expected none", cyc);
                    end else begin
                        de = done_q.pop_front();
                        if (cyc != de.cyc || bus.err_o !== de.err) begin
                            n_fail++;
                            $display("FAIL done: got cycle %0d err=%b, expected cycle %0d err=%b",
                                     cyc, bus.err_o, de.cyc, de.err);
                        end
                    end
                end
                sclk_prev = bus.sclk_o;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by cycle %0d, expected finish", cyc);
        $fatal(1, "bench timeout");
    end

    // Stimulus
    initial begin
        int t;
        bus.send_i     = 1'b0;
        bus.contador_i = 1'b0;
        bus.progress_i = 1'b0;
        bus.div_i      = 8'd2;
        rst            = 1'b1;
        tick(4);
        check_idle_outputs("reset_values");
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single word, div=2, send edge at cycle 10
        exp_half = 2;
        tick(10 - cyc);
        start_xfer();
        run_word(1'b1, 10);

        // Three words, div=3
        bus.div_i = 8'd3;
        exp_half  = 3;
        tick(2);
        start_xfer();
        run_word(1'b0, 7);
        run_word(1'b0, 9);
        run_word(1'b1, 6);

        // div=0 behaves as 1
        bus.div_i = 8'd0;
        exp_half  = 1;
        tick(2);
        start_xfer();
        run_word(1'b1, 8);

        // send held high across reset release must not start
        bus.send_i = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(8);
        bus.send_i = 1'b0;
        tick(2);

        // send pulse during TRANSFER is ignored
        bus.div_i = 8'd1;
        exp_half  = 1;
        start_xfer();
        tick(3);
        bus.send_i = 1'b1;
        tick(1);
        bus.send_i = 1'b0;
        run_word(1'b1, 4);

        // Reset in TRANSFER cycle 5, then a fresh start
        bus.div_i = 8'd2;
        exp_half  = 2;
        tick(2);
        start_xfer();
        tick(4);
        rst = 1'b1;
        ctrl_q.push_back('{3'd0, cyc + 1});
        tick(1);
        check_idle_outputs("reset_mid_xfer");
        rst = 1'b0;
        tick(3);
        start_xfer();
        run_word(1'b1, 5);

        // No contador: watchdog ends the transfer, or TRANSFER holds
        tick(2);
        start_xfer();
        t = cyc;
`ifdef SPI_TIMEOUT_EN
        ctrl_q.push_back('{3'd6, t + 15});
        ctrl_q.push_back('{3'd0, t + 16});
        done_q.push_back('{1'b1, t + 15});
        tick(20);
`else
        tick(30);
        n_run++;
        if (bus.control_o !== 3'd3 || bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL no_timeout: got ctrl=%0d busy=%b after %0d cycles, expected 3 1",
                     bus.control_o, bus.busy_o, cyc - t);
        end
        rst = 1'b1;
        ctrl_q.push_back('{3'd0, cyc + 1});
        tick(1);
        rst = 1'b0;
        tick(2);
`endif

        tick(5);
        n_run++;
        if (ctrl_q.size() != 0) begin
            n_fail++;
            $display("FAIL ctrl_drain: got %0d pending codes, expected 0", ctrl_q.size());
        end
        n_run++;
        if (done_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_drain: got %0d pending done pulses, expected 0", done_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/module_seq_spi.md
Name: module_seq_spi

Overview:
- Sequencer for the SPI control datapath: generates the 3-bit control code, the bit-clock tick and SCLK that drive the control/shift logic.
- Starts a multi-word transaction on a rising edge of the send bit from the control register.
- Sequences preload/load/transfer/check per word until the control block reports completion.
- Sits between the register bank (send, divider) and the SPI control block (control code, clk_fn, en_conta, progress).

Parameters:
- DIV_W, 8, width of SCLK half-period divisor.
- TO_W, 12, width of transfer watchdog counter (used only with SPI_TIMEOUT_EN).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- send_i  in  1  send bit from control register; level, edge-detected here
- contador_i  in  1  byte-complete flag from control block (8 ticks counted)
- progress_i  in  1  all words transferred (valid one cycle after CHECK entry)
- div_i  in  DIV_W  SCLK half-period in clk_i cycles; 0 treated as 1
- control_o  out  3  control code: 0 SEND, 1 PRELOAD1, 2 LOAD, 3 TRANSFER, 4 CHECK, 5 PRELOAD2, 6 DOWN
- clk_fn_o  out  1  one-cycle tick, once per SCLK period (at SCLK rising edge)
- sclk_o  out  1  SPI clock, CPOL=0
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse on DOWN exit
- clr_send_o  out  1  one-cycle pulse with done_o; clears register send bit
- err_o  out  1  watchdog error pulse (tied 0 without macro)

Behaviour:
- Reset: state IDLE; control_o=0, clk_fn_o=0, sclk_o=0, busy_o=0, done_o=0, clr_send_o=0, err_o=0; divider count=0; send edge register=0.
- Start: IDLE→PRELOAD1 on cycle after send_i 0→1. A level-high send_i held through reset does not start.
- Edges during busy_o=1 are ignored, not queued.
- FSM (internal 4-bit state, output code in parentheses):
  - IDLE(0) → PRELOAD1(1): 1 cycle.
  - PRELOAD1 → LOAD(2): 1 cycle.
  - LOAD → TRANSFER(3): 1 cycle.
  - TRANSFER: stays until contador_i=1, then → CHECK_A(4).
  - CHECK_A(4) → CHECK_B(4): 1 cycle; control_o held at 4 for two cycles so the registered progress_i is valid.
  - CHECK_B: progress_i=1 → DOWN(6), else → PRELOAD2(5).
  - PRELOAD2 → LOAD: 1 cycle.
  - DOWN: 1 cycle; done_o and clr_send_o pulse; → IDLE.
- Latency: send edge to control_o=3 is 3 cycles. Per word: 2 + TRANSFER + 2 (+1 PRELOAD2 if more words).
- Divider:
  - Runs only in TRANSFER; elsewhere count=0, sclk_o=0, clk_fn_o=0.
  - Counter counts 0..max(div_i,1)-1; at terminal it wraps and toggles sclk_o.
  - clk_fn_o pulses in the cycle sclk_o goes 0→1.
  - First tick occurs max(div_i,1) cycles after TRANSFER entry.
- div_i is sampled every cycle. A change mid-transfer takes effect at the next wrap; if count ≥ new terminal, the counter wraps on the next cycle.
- contador_i outside TRANSFER is ignored. progress_i outside CHECK_B is ignored.
- rst_i mid-transaction: immediate return to reset values; no done_o or clr_send_o.

Optional Feature:
- Macro: SPI_TIMEOUT_EN.
- With SPI_TIMEOUT_EN:
  - Watchdog of TO_W bits clears on TRANSFER entry and increments each TRANSFER cycle.
  - When it reaches all-ones before contador_i: → DOWN, err_o pulses one cycle together with done_o/clr_send_o.
  - contador_i and terminal in the same cycle: contador_i wins, no error.
- Without: no watchdog, err_o constant 0, TRANSFER waits indefinitely.

Decomposition:
- pkg_global gets: ctrl_code_t (logic [2:0]); CTR_SEND..CTR_DOWN constants; seq_state_t enum (IDLE, PRELOAD1, LOAD, TRANSFER, CHECK_A, CHECK_B, PRELOAD2, DOWN).
- The control block imports the same code constants.
- Sub-module: module_div_spi holds the divider, sclk_o and clk_fn_o generation, with enable = (state==TRANSFER).

Test Plan:
- Single word, div_i=2:
  - send_i 0→1 at cycle 10 → control_o 1,2,3 at cycles 11,12,13.
  - clk_fn_o pulses every 4 cycles; sclk_o period 4.
  - contador_i at cycle 50 → 4,4 at 51–52; progress_i=1 → 6 at 53; done_o and clr_send_o at 53; IDLE at 54.
- Three words:
  - progress_i=0 at first two CHECK_B → sequence 4,4,5,2,3 repeated.
  - Exactly one done_o; control_o never 6 before third CHECK_B.
- div_i=0: behaves as div_i=1 → clk_fn_o every 2 cycles, sclk_o toggles every cycle.
- send_i held high across reset release → no start. send_i pulsed during TRANSFER → ignored, single done_o.
- rst_i at TRANSFER cycle 5 → next cycle all outputs at reset values; no done_o; new send edge restarts from PRELOAD1.
- SPI_TIMEOUT_EN, TO_W=4, contador_i never asserted → after 15 TRANSFER cycles control_o=6, err_o and done_o pulse together; without macro, state stays 3.
